// File: rtl/twiddle_pkg.sv
// twiddle_pkg
//   Shared constants and types for the streaming twiddle-factor generator:
//   default geometry, quarter-wave length derivation, quadrant and burst
//   state types, and the elaboration-time cosine used to fill the ROM.
package twiddle_pkg;

  localparam int  TW_W_DEF  = 18;
  localparam int  FRAC_DEF  = 10;
  localparam int  LUT_N_DEF = 6480;   // 2^4 * 3^4 * 5, multiple of 4
  localparam int  CNT_W_DEF = 12;
  localparam real PI        = 3.14159265358979323846;

  // Quarter-wave length; the ROM holds quarter_len+1 entries.
  function automatic int quarter_len(input int lut_n);
    return lut_n / 4;
  endfunction

  typedef enum logic [1:0] {QUAD0, QUAD1, QUAD2, QUAD3} quad_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  // round-half-away(2^frac * cos(2*pi*i/lut_n)), evaluated at elaboration.
  // A plain Taylor series keeps this to basic real arithmetic; with the
  // angle limited to [0, pi/2] twelve terms are far below one LSB of error.
  function automatic int cos_fix(input int i, input int lut_n, input int frac);
    real x2;
    real term;
    real sum;
    real v;
    x2   = 2.0 * PI * real'(i) / real'(lut_n);
    x2   = x2 * x2;
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k <= 12; k++) begin
      term = -term * x2 / real'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    v = sum * real'(2 ** frac);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// twiddle_qrom
//   Quarter-wave cosine ROM, C[i] for i = 0..Q, with two independent read
//   ports. Each port registers its address on en; data is the ROM word at
//   the registered address.
//   clk, rst         : clock, asynchronous active-high reset
//   en               : pipeline advance
//   addr_a, addr_b   : read addresses (0..Q)
//   data_a, data_b   : signed TW_W cosine words
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int TW_W  = TW_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int LUT_N = LUT_N_DEF,
  parameter int AW    = $clog2(quarter_len(LUT_N) + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [AW-1:0]          addr_a,
  input  logic [AW-1:0]          addr_b,
  output logic signed [TW_W-1:0] data_a,
  output logic signed [TW_W-1:0] data_b
);

  localparam int Q = quarter_len(LUT_N);

  // NOTE: the table is constant, so it has no reset; only the address
  // registers are reset.
  logic signed [TW_W-1:0] rom [0:Q];

  for (genvar i = 0; i <= Q; i++) begin : g_rom
    localparam int C_I = cos_fix(i, LUT_N, FRAC);
    assign rom[i] = TW_W'(C_I);
  end

  logic [AW-1:0] a_q;
  logic [AW-1:0] b_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (en) begin
      a_q <= addr_a;
      b_q <= addr_b;
    end
  end

  assign data_a = rom[a_q];
  assign data_b = rom[b_q];

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen
//   Streams W = exp(-/+ j*2*pi*p/LUT_N) for p = phase0 + k*step (mod LUT_N),
//   k = 0..len-1, one sample per cycle under valid/ready flow control.
//   Pipeline: issue (phase) -> fold (quadrant/residue) -> ROM + sign (output).
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : one-cycle burst request, sampled when idle
//   cfg_phase0/step/len/inv  : burst configuration, captured on start
//   busy                     : burst accepted and not yet fully delivered
//   cfg_err                  : one-cycle pulse on a rejected start
//   tw_valid/tw_ready        : output handshake
//   tw_re, tw_im, tw_last    : twiddle value and end-of-burst marker
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int TW_W  = TW_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int LUT_N = LUT_N_DEF,
  parameter int PH_W  = $clog2(LUT_N),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PH_W-1:0]  cfg_phase0,
  input  logic [PH_W-1:0]  cfg_step,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_inv,
  output logic             busy,
  output logic             cfg_err,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic [TW_W-1:0]  tw_re,
  output logic [TW_W-1:0]  tw_im,
  output logic             tw_last
);

  localparam int              Q       = quarter_len(LUT_N);
  localparam int              AW      = $clog2(Q + 1);
  localparam logic [PH_W:0]   LUT_N_X = (PH_W + 1)'(LUT_N);
  localparam logic [PH_W-1:0] Q1      = PH_W'(Q);
  localparam logic [PH_W-1:0] Q2      = PH_W'(2 * Q);
  localparam logic [PH_W-1:0] Q3      = PH_W'(3 * Q);

  state_t                 state;
  logic [PH_W-1:0]        ph;        // issue-stage phase register
  logic [PH_W-1:0]        step_q;
  logic                   inv_q;
  logic [CNT_W-1:0]       remain;    // phases still to issue after ph
  logic                   s1_valid, s1_last;
  logic                   s2_valid, s2_last;
  quad_t                  s2_quad;

  logic                   en;
  logic                   cfg_bad;
  logic [PH_W:0]          ph_sum;
  logic [PH_W-1:0]        ph_next;
  quad_t                  quad;
  logic [PH_W-1:0]        res;
  logic [PH_W-1:0]        res_c;
  logic signed [TW_W-1:0] c_r, c_qr;
  logic signed [TW_W-1:0] re_map, im_map;

  // Every stage advances together unless a valid output is being held.
  assign en = !tw_valid || tw_ready;

  // Modular accumulate without division: one conditional subtract suffices
  // because both operands are below LUT_N.
  assign ph_sum  = {1'b0, ph} + {1'b0, step_q};
  assign ph_next = (ph_sum >= LUT_N_X) ? PH_W'(ph_sum - LUT_N_X) : ph_sum[PH_W-1:0];

  assign cfg_bad = ({1'b0, cfg_step} >= LUT_N_X) || ({1'b0, cfg_phase0} >= LUT_N_X);

  // Fold the phase onto the quarter wave: quadrant by threshold compare,
  // residue by subtracting the quadrant base.
  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    quad = QUAD0;
    res  = ph;
    if (ph >= Q3) begin
      quad = QUAD3;
      res  = ph - Q3;
    end else if (ph >= Q2) begin
      quad = QUAD2;
      res  = ph - Q2;
    end else if (ph >= Q1) begin
      quad = QUAD1;
      res  = ph - Q1;
    end
    res_c = Q1 - res;
  end

  // The ROM address registers are the residue half of the fold register.
  twiddle_qrom #(
    .TW_W  (TW_W),
    .FRAC  (FRAC),
    .LUT_N (LUT_N),
    .AW    (AW)
  ) u_qrom (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .addr_a (AW'(res)),
    .addr_b (AW'(res_c)),
    .data_a (c_r),
    .data_b (c_qr)
  );

  // Forward (exp(-j*theta)) quadrant mapping; inverse flips the imaginary sign.
  always_comb begin
    re_map = '0;
    im_map = '0;
    unique case (s2_quad)
      QUAD0: begin re_map =  c_r;  im_map = -c_qr; end
      QUAD1: begin re_map = -c_qr; im_map = -c_r;  end
      QUAD2: begin re_map = -c_r;  im_map =  c_qr; end
      QUAD3: begin re_map =  c_qr; im_map =  c_r;  end
      default: ;
    endcase
    if (inv_q) im_map = -im_map;
  end

  // Burst control and issue stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
      ph       <= '0;
      step_q   <= '0;
      inv_q    <= 1'b0;
      remain   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else if (cfg_len != '0) begin
              ph       <= cfg_phase0;
              step_q   <= cfg_step;
              inv_q    <= cfg_inv;
              remain   <= cfg_len - CNT_W'(1);
              s1_valid <= 1'b1;
              s1_last  <= (cfg_len == CNT_W'(1));
              busy     <= 1'b1;
              state    <= (cfg_len == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (en) begin
            ph      <= ph_next;
            s1_last <= (remain == CNT_W'(1));
            remain  <= remain - CNT_W'(1);
            if (remain == CNT_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (en) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
          end
          if (tw_valid && tw_ready && tw_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fold register (quadrant side) and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_quad  <= QUAD0;
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      s2_quad  <= quad;
      tw_valid <= s2_valid;
      tw_last  <= s2_valid && s2_last;
      tw_re    <= s2_valid ? re_map : '0;
      tw_im    <= s2_valid ? im_map : '0;
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen
//   Self-checking bench for twiddle_gen. Expected samples come from a direct
//   complex-exponential model: p = (phase0 + k*step) mod LUT_N, then
//   re = round(1024*cos), im = -/+ round(1024*sin) with half-away rounding.
module tb_twiddle_gen;

  localparam int  TW_W  = 18;
  localparam int  FRAC  = 10;
  localparam int  LUT_N = 6480;
  localparam int  PH_W  = 13;
  localparam int  CNT_W = 12;
  localparam real PI    = 3.14159265358979323846;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [PH_W-1:0]        cfg_phase0 = '0;
  logic [PH_W-1:0]        cfg_step = '0;
  logic [CNT_W-1:0]       cfg_len = '0;
  logic                   cfg_inv = 1'b0;
  logic                   busy, cfg_err, tw_valid, tw_last;
  logic                   tw_ready = 1'b1;
  logic signed [TW_W-1:0] tw_re, tw_im;

  int n_vec = 0;
  int n_err = 0;
  int got_re[$], got_im[$], ref_re[$], ref_im[$];
  int divs [18] = '{2, 3, 4, 5, 8, 9, 12, 15, 16, 24, 27, 36, 45, 60, 81, 135, 324, 6480};

  always #5 clk = ~clk;

  twiddle_gen #(
    .TW_W(TW_W), .FRAC(FRAC), .LUT_N(LUT_N), .PH_W(PH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_phase0(cfg_phase0), .cfg_step(cfg_step), .cfg_len(cfg_len), .cfg_inv(cfg_inv),
    .busy(busy), .cfg_err(cfg_err), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_re(tw_re), .tw_im(tw_im), .tw_last(tw_last)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(0.5 - v));
  endfunction

  function automatic int model_re(input int p);
    return rnd(1024.0 * $cos(2.0 * PI * real'(p) / real'(LUT_N)));
  endfunction

  function automatic int model_im(input int p, input bit inv);
    int s;
    s = rnd(1024.0 * $sin(2.0 * PI * real'(p) / real'(LUT_N)));
    return inv ? s : -s;
  endfunction

  // Launch one burst and consume it. stall_pct randomly drops ready;
  // [stall_at, stall_at+stall_len) forces ready low; poke_at re-pulses start.
  task automatic run_burst(input int ph0, input int st, input int len, input bit inv,
                           input int stall_pct, input int stall_at, input int stall_len,
                           input int poke_at);
    int idx, c, first_c, p;
    bit hold;
    logic signed [TW_W-1:0] h_re, h_im;
    logic h_last;
    got_re.delete();
    got_im.delete();
    cfg_phase0 = PH_W'(ph0);
    cfg_step   = PH_W'(st);
    cfg_len    = CNT_W'(len);
    cfg_inv    = inv;
    start      = 1'b1;
    idx = 0; c = 0; first_c = -1; hold = 1'b0; h_re = '0; h_im = '0; h_last = 1'b0;
    while (idx < len && c < 4 * len + 200) begin
      @(negedge clk);
      c++;
      start      = (c == poke_at);
      cfg_phase0 = PH_W'($urandom);
      cfg_step   = PH_W'($urandom);
      cfg_len    = CNT_W'($urandom);
      cfg_inv    = 1'($urandom);
      if (c == 1) check("busy_rise", busy, 1);
      if (poke_at > 0 && c == poke_at + 1) check("poke_no_err", cfg_err, 0);
      tw_ready = !((c >= stall_at && c < stall_at + stall_len) ||
                   ($urandom_range(99) < stall_pct));
      if (hold) begin
        check("hold_re", tw_re, h_re);
        check("hold_im", tw_im, h_im);
        check("hold_last", tw_last, h_last);
      end
      if (tw_valid && first_c < 0) begin
        first_c = c;
        check("latency", c, 3);
      end
      if (tw_valid && tw_ready) begin
        p = (ph0 + idx * st) % LUT_N;
        check($sformatf("re[%0d] p=%0d", idx, p), tw_re, model_re(p));
        check($sformatf("im[%0d] p=%0d", idx, p), tw_im, model_im(p, inv));
        check($sformatf("last[%0d]", idx), tw_last, (idx == len - 1));
        got_re.push_back(int'(tw_re));
        got_im.push_back(int'(tw_im));
        idx++;
      end
      hold   = tw_valid && !tw_ready;
      h_re   = tw_re;
      h_im   = tw_im;
      h_last = tw_last;
    end
    check("count", idx, len);
    start    = 1'b0;
    tw_ready = 1'b1;
    @(negedge clk);
    check("busy_fall", busy, 0);
    check("drained", tw_valid, 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (tw_valid || busy || cfg_err) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  task automatic err_start(input string tag, input int ph0, input int st);
    cfg_phase0 = PH_W'(ph0);
    cfg_step   = PH_W'(st);
    cfg_len    = CNT_W'(5);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_pulse"}, cfg_err, 0);
    idle_check({tag, "_idle"}, 5);
  endtask

  function automatic int queue_diff(input int a[$], input int b[$]);
    int d;
    d = (a.size() == b.size()) ? 0 : 1;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", cfg_err, 0);
    check("rst_valid", tw_valid, 0);
    check("rst_last", tw_last, 0);
    check("rst_re", tw_re, 0);
    check("rst_im", tw_im, 0);
    rst = 1'b0;
    @(negedge clk);

    // N = 81, forward
    run_burst(0, 80, 81, 1'b0, 0, 0, 0, 0);
    check("n81_s0_re", got_re[0], 1024);
    check("n81_s0_im", got_im[0], 0);
    check("n81_s20_re", got_re[20], 20);
    check("n81_s20_im", got_im[20], -1024);
    ref_re = got_re;
    ref_im = got_im;

    // Same burst, inverse
    run_burst(0, 80, 81, 1'b1, 0, 0, 0, 0);
    check("n81inv_s20_re", got_re[20], 20);
    check("n81inv_s20_im", got_im[20], 1024);
    check("n81inv_re_same", queue_diff(got_re, ref_re), 0);

    // N = 12
    run_burst(0, 540, 12, 1'b0, 0, 0, 0, 0);
    check("n12_s3_re", got_re[3], 0);
    check("n12_s3_im", got_im[3], -1024);
    check("n12_s6_re", got_re[6], -1024);
    check("n12_s6_im", got_im[6], 0);
    check("n12_s9_re", got_re[9], 0);
    check("n12_s9_im", got_im[9], 1024);

    // Phase wrap
    run_burst(6400, 100, 2, 1'b0, 0, 0, 0, 0);
    check("wrap_s1_re", got_re[1], 1024);
    check("wrap_s1_im", got_im[1], -20);

    // Backpressure mid-burst plus a start while busy
    run_burst(0, 80, 81, 1'b0, 0, 30, 5, 10);
    check("stall_re_same", queue_diff(got_re, ref_re), 0);
    check("stall_im_same", queue_diff(got_im, ref_im), 0);
    idle_check("busy_start_ignored", 6);

    // Rejected starts and the zero-length no-op
    err_start("step_bad", 0, 6480);
    err_start("ph0_bad", 7000, 80);
    cfg_phase0 = '0; cfg_step = PH_W'(80); cfg_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_err", cfg_err, 0);
    idle_check("len0_idle", 5);

    // Random bursts, back to back, random backpressure
    for (int b = 0; b < 12; b++) begin
      int n, m;
      n = divs[$urandom_range(17)];
      m = $urandom_range(n - 1);
      run_burst($urandom_range(LUT_N - 1), (LUT_N / n) * m, $urandom_range(40, 1),
                1'($urandom), 25, 0, 0, 0);
    end

    // Reset mid-burst
    cfg_phase0 = '0; cfg_step = PH_W'(80); cfg_len = CNT_W'(81); cfg_inv = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", tw_valid, 0);
    check("midrst_last", tw_last, 0);
    check("midrst_re", tw_re, 0);
    check("midrst_im", tw_im, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check("midrst_idle", 3);
    run_burst(0, 540, 12, 1'b1, 10, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised streaming twiddle-factor generator for the PUSCH DFT/IDFT engines. It replaces the per-size fixed twiddle tables with one quarter-wave cosine ROM of resolution LUT_N. A phase accumulator serves any transform size N that divides LUT_N, any exponent stride, and forward or inverse sign. It sits beside the butterfly datapath and streams one W = exp(∓j2π·p/LUT_N) per cycle under valid/ready flow control.

## Interface
- TW_W, 18: twiddle word width, two's complement.
- FRAC, 10: fractional bits; 1.0 = 2^FRAC = 1024.
- LUT_N, 6480: phase resolution (2^4·3^4·5). Must be a multiple of 4.
- PH_W, $clog2(LUT_N): phase width.
- CNT_W, 12: burst length width.
- clk  in  1  master clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle burst request; sampled only when idle.
- cfg_phase0  in  PH_W  phase of first sample.
- cfg_step  in  PH_W  phase increment per sample; equals (LUT_N/N)·m.
- cfg_len  in  CNT_W  number of samples in the burst.
- cfg_inv  in  1  0 gives exp(−jθ) (FFT); 1 gives exp(+jθ) (IFFT).
- busy  out  1  burst accepted and not fully delivered.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- tw_valid  out  1  output sample valid.
- tw_ready  in  1  consumer accepts the sample.
- tw_re, tw_im  out  TW_W each  twiddle value.
- tw_last  out  1  marks the final sample of the burst.

## Operation
- Q = LUT_N/4. The ROM holds C[i] = round-half-away(2^FRAC·cos(2πi/LUT_N)) for i = 0..Q (Q+1 entries). Values are computed at elaboration.
- Phase accumulator: p0 = cfg_phase0. Next p = p + cfg_step, minus LUT_N if the sum is ≥ LUT_N. The sum is computed at PH_W+1 bits. No division is used.
- Fold: quadrant q = count of thresholds Q, 2Q, 3Q that are ≤ p. r = p − q·Q. The ROM is read at C[r] and C[Q−r] (dual read).
- Forward mapping:
  - q0: re = C[r], im = −C[Q−r]
  - q1: re = −C[Q−r], im = −C[r]
  - q2: re = −C[r], im = +C[Q−r]
  - q3: re = +C[Q−r], im = +C[r]
- cfg_inv = 1 negates im only. Negation of 0 yields 0.
- Burst states and transitions:
  - IDLE → RUN on an accepted start.
  - RUN issues one phase per enabled cycle and decrements the remaining count.
  - RUN → DRAIN after the last phase is issued.
  - DRAIN → IDLE when the sample carrying tw_last is accepted.
- start rules:
  - start while busy is ignored silently.
  - start with cfg_step ≥ LUT_N or cfg_phase0 ≥ LUT_N is rejected: cfg_err pulses for 1 cycle and the block stays IDLE.
  - cfg_len = 0 is a no-op: no output, busy stays 0, no error.
- Config is captured at start. Later changes to the cfg inputs have no effect on a running burst.

## Timing
- Reset values: busy, cfg_err, tw_valid, tw_last = 0; tw_re, tw_im = 0; state IDLE.
- Pipeline has 3 stages:
  - issue (phase register)
  - fold (quadrant/residue register)
  - ROM read + sign mapping into the output register
- start sampled at edge t → first tw_valid at t+3. busy rises at t+1.
- Throughput is 1 sample/cycle while tw_ready = 1.
- Stall: global enable = !tw_valid | tw_ready.
  - While tw_valid = 1 and tw_ready = 0, every stage holds.
  - tw_re, tw_im and tw_last stay stable; no sample is lost or duplicated.
- busy falls in the cycle after the tw_last handshake. A new start is accepted in that same cycle.
- rst mid-burst clears all stages asynchronously. In-flight samples are discarded and no tw_last is emitted.

## Structure
- Package twiddle_pkg holds:
  - LUT_N/Q constant derivation
  - the quadrant type
  - the elaboration-time cosine function used to fill the ROM
- One sub-module, twiddle_qrom: a (Q+1)-entry quarter cosine ROM with two registered read ports.
- Accumulator, FSM, fold and sign stages live in twiddle_gen.

## Test plan
- N=81 (cfg_step=80), phase0=0, len=81, inv=0, ready=1:
  - sample 0 = (1024, 0)
  - sample 20 (p=1600) = (20, −1024)
  - tw_last only on sample 80
  - first valid exactly 3 cycles after start
- Same burst with inv=1 → sample 20 = (20, +1024); all re values unchanged.
- N=12 (cfg_step=540), len=12:
  - sample 3 = (0, −1024)
  - sample 6 = (−1024, 0)
  - sample 9 = (0, +1024)
- Wrap: phase0=6400, step=100, len=2 → (C[6400 fold], …), then p=20 → (1024, −20).
- Backpressure: drop tw_ready for 5 cycles mid-burst → outputs frozen; sequence identical to the unstalled run; count is still 81.
- Errors and reset:
  - cfg_step=6480 → cfg_err pulse, busy stays 0, no output.
  - start while busy → ignored.
  - rst asserted mid-burst → all outputs 0 immediately; the next start behaves as from reset.
